// File: rtl/fsqrt_pkg.sv
// fsqrt_pkg: shared constants, state encoding and operand classification for the sqrt issue stage
package fsqrt_pkg;
    localparam logic [31:0] QNAN     = 32'h7fc00000;
    localparam logic [31:0] POS_INF  = 32'h7f800000;
    localparam logic [31:0] POS_ZERO = 32'h00000000;
    localparam logic [31:0] NEG_ZERO = 32'h80000000;

    typedef enum logic [1:0] {
        RM_NEAREST = 2'b00,
        RM_ZERO    = 2'b01,
        RM_DOWN    = 2'b10,
        RM_UP      = 2'b11
    } rm_e;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_neg;
    } op_class_t;

    function automatic op_class_t classify(input logic [31:0] d);
        op_class_t c;
        c.is_zero = d[30:0] == 31'h0;
        c.is_inf  = d[30:23] == 8'hff && d[22:0] == 23'h0;
        c.is_nan  = d[30:23] == 8'hff && d[22:0] != 23'h0;
        c.is_neg  = d[31];
        return c;
    endfunction
endpackage

// File: rtl/sqrt_req_fifo.sv
// sqrt_req_fifo: synchronous request FIFO with full/empty flags
module sqrt_req_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;

    assign rdata = mem[rptr];
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/fsqrt_issue_ctrl.sv
// fsqrt_issue_ctrl: buffers sqrt requests, issues them one at a time to the Newton core,
// resolves special operands locally and guards the core with a watchdog
module fsqrt_issue_ctrl
    import fsqrt_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_d,
    input  logic [1:0]       in_rm,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      core_d,
    output logic [1:0]       core_rm,
    output logic             core_fsqrt,
    output logic             core_ena,
    input  logic [31:0]      core_s,
    input  logic             core_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_s,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_bypass,
    output logic             out_err
);
    localparam int W  = 32 + 2 + TAG_W;
    localparam int TW = $clog2(TIMEOUT);

    state_e           state, state_nxt;
    logic [31:0]      op_d;
    logic [1:0]       op_rm;
    logic [TAG_W-1:0] op_tag;
    logic [TW-1:0]    timer;
    logic             full, empty, push, pop;
    logic [W-1:0]     head;
    logic [31:0]      head_d;
    logic [1:0]       head_rm;
    logic [TAG_W-1:0] head_tag;
    op_class_t        cls;
    logic             special, core_done, timed_out;
    logic [31:0]      byp_s;

    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = state == IDLE && !empty;

    sqrt_req_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata ({in_d, in_rm, in_tag}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign {head_d, head_rm, head_tag} = head;
    assign cls     = classify(head_d);
    assign special = cls.is_zero || cls.is_inf || cls.is_nan || cls.is_neg;
    assign byp_s   = cls.is_zero ? (cls.is_neg ? NEG_ZERO : POS_ZERO) :
                     (cls.is_nan || cls.is_neg) ? QNAN : POS_INF;

    // timer==0 is the first WAIT cycle, where core_valid may still be left over from the previous op
    assign core_done = state == WAIT && core_valid && timer != '0;
    assign timed_out = state == WAIT && timer == TW'(TIMEOUT - 1);

    assign core_d     = op_d;
    assign core_rm    = op_rm;
    assign core_fsqrt = state == ISSUE;
    assign core_ena   = state == ISSUE || state == WAIT;
    assign out_valid  = state == HOLD;
    assign out_tag    = op_tag;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = empty ? IDLE : special ? HOLD : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = (core_done || timed_out) ? HOLD : WAIT;
            HOLD:    state_nxt = out_ready ? IDLE : HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_d       <= '0;
            op_rm      <= '0;
            op_tag     <= '0;
            out_s      <= '0;
            out_bypass <= 1'b0;
            out_err    <= 1'b0;
            timer      <= '0;
        end else begin
            if (pop) begin
                op_d   <= head_d;
                op_rm  <= head_rm;
                op_tag <= head_tag;
                if (special) {out_s, out_bypass, out_err} <= {byp_s, 2'b10};
            end
            timer <= state == WAIT ? timer + 1'b1 : '0;
            if (core_done) {out_s, out_bypass, out_err} <= {core_s, 2'b00};
            else if (timed_out) {out_s, out_bypass, out_err} <= {QNAN, 2'b01};
        end
    end
endmodule

// File: tb/tb_fsqrt_issue_ctrl.sv
// tb_fsqrt_issue_ctrl: randomized and directed checks of the sqrt issue stage against a queue-based reference
module tb_fsqrt_issue_ctrl;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 64;
    localparam logic [31:0] QNAN = 32'h7fc00000;

    typedef struct {
        logic [31:0]      d;
        logic [1:0]       rm;
        logic [TAG_W-1:0] tag;
    } req_t;

    logic             clk = 0, rstn = 0;
    logic             in_valid = 0, out_ready = 0;
    logic [31:0]      in_d = 0;
    logic [1:0]       in_rm = 0;
    logic [TAG_W-1:0] in_tag = 0;
    logic             in_ready, core_fsqrt, core_ena, out_valid, out_bypass, out_err;
    logic [31:0]      core_d, out_s;
    logic [1:0]       core_rm;
    logic [TAG_W-1:0] out_tag;
    logic [31:0]      core_s = 0;
    logic             core_valid = 0;

    int checks = 0, passes = 0;
    int fs_cnt = 0, acc_cnt = 0, core_lat = 10, ccnt = 0;
    bit rand_mode = 0, done = 0, pv = 0, pr = 0;
    req_t exp_q[$];
    req_t iss_q[$];
    int   lat_q[$];

    fsqrt_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d),
        .in_rm(in_rm), .in_tag(in_tag), .core_d(core_d), .core_rm(core_rm),
        .core_fsqrt(core_fsqrt), .core_ena(core_ena), .core_s(core_s), .core_valid(core_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_tag(out_tag),
        .out_bypass(out_bypass), .out_err(out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
        $fatal(1, "simulation did not terminate");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // {special, value}: the result a special operand resolves to without the core
    function automatic logic [32:0] bref(input logic [31:0] d);
        if (d == 32'h0) return {1'b1, 32'h0};
        if (d == 32'h80000000) return {1'b1, 32'h80000000};
        if (d[30:23] == 8'hff && d[22:0] != 0) return {1'b1, QNAN};
        if (d[31]) return {1'b1, QNAN};
        if (d == 32'h7f800000) return {1'b1, 32'h7f800000};
        return 33'h0;
    endfunction

    function automatic logic [31:0] sqrt_ref(input logic [31:0] d);
        return (d >> 1) + 32'h1fc00000;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 9))
            0: return {r[0], 31'h0};
            1: return {r[0], 8'hff, 23'h0};
            2: return {r[0], 8'hff, r[22:1], 1'b1};
            3: return {1'b1, r[30:0]};
            4: return {9'h0, r[22:1], 1'b1};
            default: return {1'b0, 8'(r[30:23] % 8'd254 + 8'd1), r[22:0]};
        endcase
    endfunction

    // acceptance monitor and core model (fixed or random latency, level-valid until next start)
    always @(posedge clk) begin : mon
        logic [32:0] b;
        req_t r;
        int l;
        if (rstn && in_valid && in_ready) begin
            r = '{in_d, in_rm, in_tag};
            exp_q.push_back(r);
            acc_cnt++;
            b = bref(in_d);
            if (!b[32]) iss_q.push_back(r);
        end
        if (core_fsqrt) begin
            fs_cnt++;
            if (iss_q.size() == 0) begin
                checks++;
                $display("FAIL fsqrt: start pulse with core_d=%h but no core request pending", core_d);
            end else begin
                r = iss_q.pop_front();
                chk("core issue d/rm/ena", {core_d, core_rm, core_ena}, {r.d, r.rm, 1'b1});
            end
            l = !rand_mode ? core_lat : ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 67)) : int'($urandom_range(1, 20));
            lat_q.push_back(l);
            ccnt = l;
            core_valid <= 1'b0;
            core_s <= sqrt_ref(core_d);
        end else if (ccnt > 0) begin
            ccnt--;
            if (ccnt == 0) core_valid <= 1'b1;
        end
    end

    // output scoreboard
    always @(negedge clk) begin : cmp
        req_t h;
        logic [32:0] b;
        logic err;
        if (!rstn) begin
            pv = 0;
            pr = 0;
        end else begin
            if (pv && !pr) chk("out_valid held", out_valid, 1'b1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL out: result s=%h tag=%h with no request pending", out_s, out_tag);
                end else begin
                    h = exp_q[0];
                    b = bref(h.d);
                    if (b[32]) begin
                        chk("out bypass", {out_s, out_tag, out_bypass, out_err}, {b[31:0], h.tag, 2'b10});
                        if (out_ready) void'(exp_q.pop_front());
                    end else if (lat_q.size() == 0) begin
                        checks++;
                        $display("FAIL out: core result tag=%h for a request never issued", out_tag);
                        if (out_ready) void'(exp_q.pop_front());
                    end else begin
                        err = lat_q[0] > TIMEOUT - 1;
                        chk("out core", {out_s, out_tag, out_bypass, out_err},
                            {err ? QNAN : sqrt_ref(h.d), h.tag, 1'b0, err});
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            void'(lat_q.pop_front());
                        end
                    end
                end
            end
            pv = out_valid;
            pr = out_ready;
        end
    end

    task automatic push(input logic [31:0] d, input logic [1:0] rm, input logic [TAG_W-1:0] tag);
        logic r;
        r = 0;
        in_valid = 1;
        in_d = d;
        in_rm = rm;
        in_tag = tag;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            if (r) break;
        end
        #1 in_valid = 0;
        if (!r) begin
            checks++;
            $display("FAIL push: tag %h not accepted, in_ready stayed 0", tag);
        end
    endtask

    task automatic wait_out(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            $display("FAIL wait_out: out_valid 0 after %0d cycles, expected 1", bound);
        end
    endtask

    task automatic take();
        @(posedge clk);
        #1 out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
    endtask

    task automatic wait_fs(input int target);
        for (int n = 0; n < 500 && fs_cnt < target; n++) @(posedge clk);
        #1;
        if (fs_cnt < target) begin
            checks++;
            $display("FAIL wait_fs: %0d start pulses, expected %0d", fs_cnt, target);
        end
    endtask

    task automatic drain(input int bound);
        out_ready = 1;
        for (int n = 0; n < bound && exp_q.size() != 0; n++) @(posedge clk);
        #1 out_ready = 0;
        chk("drain empty", exp_q.size(), 0);
    endtask

    task automatic chk_reset(input string n);
        chk(n, {in_ready, out_valid, core_fsqrt, core_ena, core_d, core_rm, out_s, out_tag, out_bypass, out_err},
            {1'b1, 75'h0});
    endtask

    initial begin
        int f0, a0, nv;
        #1 chk_reset("reset outputs");
        repeat (2) @(posedge clk);
        #1 rstn = 1;

        // normal core path
        core_lat = 10;
        f0 = fs_cnt;
        push(32'h40800000, 2'b00, 4'd3);
        wait_out(100);
        chk("core result", {out_s, out_tag, out_bypass, out_err}, {32'h40000000, 4'd3, 2'b00});
        chk("one start pulse", fs_cnt - f0, 1);
        take();

        // bypassed operands
        f0 = fs_cnt;
        push(32'hbf800000, 2'b01, 4'd1);
        push(32'h7f800000, 2'b00, 4'd2);
        wait_out(20);
        chk("bypass -1", {out_s, out_tag, out_bypass, out_err}, {QNAN, 4'd1, 2'b10});
        take();
        wait_out(20);
        chk("bypass +inf", {out_s, out_tag, out_bypass, out_err}, {32'h7f800000, 4'd2, 2'b10});
        take();
        chk("no start pulse on bypass", fs_cnt - f0, 0);

        // fill with a stalled core
        core_lat = 40;
        f0 = fs_cnt;
        push(32'h40800000, 2'b00, 4'd0);
        wait_fs(f0 + 1);
        a0 = acc_cnt;
        for (int k = 0; k < DEPTH + 3; k++) begin
            in_valid = 1;
            in_d = 32'h3f800000 + 32'(k << 20);
            in_rm = 2'(k);
            in_tag = TAG_W'(k + 1);
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        chk("accepts when full", acc_cnt - a0, DEPTH);
        chk("in_ready low when full", in_ready, 1'b0);
        drain(2000);

        // hold stability under backpressure
        core_lat = 10;
        push(32'h00000000, 2'b00, 4'd7);
        push(32'h40800000, 2'b00, 4'd8);
        wait_out(20);
        f0 = fs_cnt;
        repeat (20) @(negedge clk);
        chk("hold stable", {out_valid, out_s, out_tag, out_bypass, out_err}, {1'b1, 32'h0, 4'd7, 2'b10});
        chk("no start during hold", fs_cnt - f0, 0);
        take();
        chk("out_valid falls", out_valid, 1'b0);
        wait_out(100);
        chk("after hold", {out_s, out_tag, out_bypass, out_err}, {32'h40000000, 4'd8, 2'b00});
        take();

        // latency boundary and watchdog
        core_lat = TIMEOUT - 1;
        push(32'h41100000, 2'b10, 4'd4);
        wait_out(200);
        chk("latency 63", {out_s, out_tag, out_err}, {32'h40480000, 4'd4, 1'b0});
        take();
        core_lat = TIMEOUT;
        push(32'h41100000, 2'b00, 4'd5);
        wait_out(200);
        chk("latency 64", {out_s, out_tag, out_bypass, out_err}, {QNAN, 4'd5, 2'b01});
        take();
        core_lat = 100000;
        push(32'h40800000, 2'b00, 4'd9);
        wait_out(300);
        chk("hung core", {out_s, out_tag, out_bypass, out_err}, {QNAN, 4'd9, 2'b01});
        take();
        core_lat = 10;
        push(32'h40800000, 2'b00, 4'd10);
        wait_out(100);
        chk("after timeout", {out_s, out_tag, out_bypass, out_err}, {32'h40000000, 4'd10, 2'b00});
        take();

        // reset during WAIT with two entries queued
        core_lat = 30;
        f0 = fs_cnt;
        push(32'h40800000, 2'b00, 4'd11);
        push(32'h40800000, 2'b00, 4'd12);
        push(32'h40800000, 2'b00, 4'd13);
        wait_fs(f0 + 1);
        @(posedge clk);
        #3 rstn = 0;
        #1 chk_reset("mid-op reset outputs");
        exp_q.delete();
        iss_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1 rstn = 1;
        nv = 0;
        repeat (80) @(negedge clk) if (out_valid) nv++;
        chk("no stale result", nv, 0);
        @(posedge clk);
        #1 push(32'h40800000, 2'b00, 4'd14);
        wait_out(100);
        chk("after reset", {out_s, out_tag, out_bypass, out_err}, {32'h40000000, 4'd14, 2'b00});
        take();

        // randomized traffic
        rand_mode = 1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    push(rand_op(), 2'($urandom_range(0, 3)), TAG_W'(i));
                end
                for (int n = 0; n < 20000 && exp_q.size() != 0; n++) @(posedge clk);
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 0;
            end
        join
        chk("random drain", exp_q.size(), 0);
        chk("all issued", iss_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fsqrt_issue_ctrl.md
Name: fsqrt_issue_ctrl

Overview:
- Front-end stage for the multi-cycle Newton square-root core.
- Buffers tagged sqrt requests in a small FIFO and issues them one at a time to the core, driving its fsqrt/ena interface.
- Waits for the core result, then presents it downstream with a tagged valid/ready handshake.
- Resolves special operands (±0, +Inf, NaN, negative) locally without occupying the core. A watchdog covers a hung core.

Parameters:
- DEPTH, 4, request FIFO entries; power of 2, ≥2.
- TAG_W, 4, request tag width.
- TIMEOUT, 64, max cycles in WAIT before forced error result; ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_d  in  32  IEEE-754 single operand.
- in_rm  in  2  rounding mode.
- in_tag  in  TAG_W  request tag.
- core_d  out  32  operand to core.
- core_rm  out  2  rounding mode to core.
- core_fsqrt  out  1  one-cycle start pulse to core.
- core_ena  out  1  core enable.
- core_s  in  32  core result.
- core_valid  in  1  core result valid (level).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_s  out  32  result.
- out_tag  out  TAG_W  tag of result.
- out_bypass  out  1  result produced locally.
- out_err  out  1  result forced by watchdog.

Behaviour:
- Reset (async, rstn=0): FIFO empty, state IDLE, timer 0. All outputs 0 except in_ready=1.
- Reset mid-operation discards buffered and in-flight requests. Core outputs are ignored until the next ISSUE.
- FIFO:
  - in_ready = !full (combinational from occupancy).
  - Push on in_valid & in_ready. Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave occupancy unchanged.
- Single outstanding request. Results leave in request order.
- State machine IDLE, ISSUE, WAIT, HOLD:
  - IDLE, FIFO non-empty: pop head into op_d/op_rm/op_tag. Classify op_d:
    - +0 → 0x00000000
    - -0 → 0x80000000
    - +Inf → 0x7f800000
    - NaN (exp=0xFF, frac≠0) → 0x7fc00000
    - sign=1 and nonzero (incl. -Inf, negative denormal) → 0x7fc00000
    - On any special case: load out_s, set out_bypass=1, go to HOLD.
    - Otherwise go to ISSUE. Positive denormals go to the core.
  - IDLE, FIFO empty: stay.
  - ISSUE (1 cycle): core_d=op_d, core_rm=op_rm, core_fsqrt=1, core_ena=1. Timer cleared. Go to WAIT.
  - WAIT: core_ena=1, core_fsqrt=0, core_d/core_rm held stable, timer increments each cycle.
    - core_valid=1 on a cycle with timer ≥1: capture core_s into out_s, out_bypass=0, out_err=0, go to HOLD. core_valid during the ISSUE cycle is ignored (stale).
    - Else timer==TIMEOUT-1: out_s=0x7fc00000, out_err=1, go to HOLD.
    - core_valid has priority over timeout on the same cycle.
  - HOLD: out_valid=1. out_s/out_tag/out_bypass/out_err held stable. core_ena=0.
    - On out_ready, go to IDLE; out_valid falls next cycle.
- Throughput: min 2 cycles per bypass result (IDLE, HOLD); core results take core latency + 3.
- core_fsqrt never pulses for bypassed operands.
- out_valid never drops without out_ready.

Decomposition:
- Shared package fsqrt_pkg:
  - QNAN=32'h7fc00000, POS_INF=32'h7f800000, POS_ZERO, NEG_ZERO.
  - Rounding-mode encodings (2'b00 = nearest).
  - State enum IDLE/ISSUE/WAIT/HOLD.
  - Operand-classification function (is_zero, is_inf, is_nan, is_neg).
- One sub-module: sqrt_req_fifo. Synchronous FIFO, width 32+2+TAG_W, DEPTH entries, async active-low reset, full/empty flags.

Test Plan:
- Core model returning 0x40000000 after 10 cycles; push d=0x40800000 tag=3 → one core_fsqrt pulse with core_d=0x40800000; out_s=0x40000000, out_tag=3, out_bypass=0, out_err=0.
- Push 0xbf800000 tag=1, then 0x7f800000 tag=2 → out_s 0x7fc00000 then 0x7f800000, both out_bypass=1, zero core_fsqrt pulses.
- Core stalled; push DEPTH+1 requests back-to-back → in_ready low after DEPTH accepts. After release, tags emerge in push order with no loss or duplication.
- out_ready held low 20 cycles with result in HOLD → out_valid stays 1, out_s/out_tag stable, no new core_fsqrt pulse. Advance on the first out_ready.
- Core never asserts core_valid → after TIMEOUT cycles in WAIT: out_s=0x7fc00000, out_err=1. The next request issues normally.
- Deassert rstn during WAIT with 2 entries queued → all outputs reset immediately, in_ready=1. No stale result appears after rstn rises.
